dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Sequences MEM-stage data-memory accesses against a variable-latency data memory using a req/ack handshake.
- Takes MemRead/MemWrite, address and store data from the EX/MEM pipeline register outputs.
- Drives Stall_o to freeze EX/MEM and all upstream pipeline registers until the access completes.
- Returns load data to the MEM/WB path, flags memory timeouts and counts stall cycles for performance analysis.

Parameters:
- TIMEOUT, 64: maximum BUSY cycles without mem_ack_i before the access is aborted.
- CNT_W, 16: width of the saturating stall-cycle counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- MemRead_i  in  1  load request from EX/MEM.
- MemWrite_i  in  1  store request from EX/MEM.
- Addr_i  in  32  data address (EX/MEM RegData).
- WData_i  in  32  store data (EX/MEM MemData).
- Stall_o  out  1  freezes EX/MEM and upstream pipeline registers (combinational).
- RData_o  out  32  load data, valid in DONE.
- mem_req_o  out  1  registered memory request, held until ack or timeout.
- mem_we_o  out  1  registered; 1 = write, 0 = read.
- mem_addr_o  out  32  registered address.
- mem_wdata_o  out  32  registered write data.
- mem_ack_i  in  1  memory completion; one cycle, sampled only in BUSY.
- mem_rdata_i  in  32  read data, valid together with mem_ack_i.
- err_o  out  1  sticky timeout flag.
- stall_cnt_o  out  CNT_W  saturating count of cycles with Stall_o = 1.

Behaviour:
- Reset (rst_i = 0, asynchronous):
  - state = IDLE.
  - mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, RData_o, err_o, stall_cnt_o and the timeout counter all = 0.
  - Reset asserted mid-access drops mem_req_o immediately; the access is abandoned and a late ack is ignored.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - access = MemRead_i | MemWrite_i; Stall_o = access.
  - If access is 1, at the next edge: mem_req_o <= 1, mem_we_o <= MemWrite_i, and Addr_i and WData_i are captured; timeout counter <= 0; next state BUSY.
  - If MemRead_i and MemWrite_i are both 1, the write is performed (mem_we_o = 1).
- BUSY:
  - Stall_o = 1; mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o hold steady.
  - On mem_ack_i = 1: mem_req_o <= 0; RData_o <= mem_rdata_i for a read, unchanged for a write; next state DONE.
  - Otherwise the counter increments. When the counter equals TIMEOUT-1 with no ack: mem_req_o <= 0, RData_o <= 0, err_o <= 1, next state DONE.
  - An ack in the timeout cycle takes precedence over the timeout.
- DONE:
  - Stall_o = 0, so the pipeline advances at this edge; RData_o is valid for the MEM/WB latch.
  - No new request is issued, because EX/MEM still presents the completed instruction.
  - Next state is IDLE unconditionally.
- mem_ack_i in IDLE or DONE is ignored.
- Minimum latency per memory instruction: 3 cycles (IDLE issue, BUSY with ack, DONE); the pipeline stalls 2 cycles.
- Non-memory instructions in IDLE: Stall_o = 0, zero added latency.
- Back-to-back memory instructions: the second is issued from IDLE in the cycle after DONE.
- stall_cnt_o increments on every edge where Stall_o = 1 and saturates at all-ones.
- err_o clears only on reset.

Test Plan:
- Reset and idle: rst_i low, then high with MemRead_i = MemWrite_i = 0 for 5 cycles → Stall_o = 0, mem_req_o = 0, all outputs 0, stall_cnt_o = 0.
- Load with 3-cycle memory latency: MemRead_i = 1, Addr_i = 0x100; memory acks in the 3rd BUSY cycle with rdata 0xDEADBEEF → mem_req_o high for exactly 3 cycles with mem_we_o = 0 and mem_addr_o = 0x100; Stall_o high for 4 cycles, then low in DONE with RData_o = 0xDEADBEEF; stall_cnt_o = 4.
- Store with 1-cycle ack: MemWrite_i = 1, Addr_i = 0x20, WData_i = 0x55AA → mem_we_o = 1 and mem_wdata_o = 0x55AA; Stall_o high for 2 cycles; RData_o unchanged.
- Back-to-back: store immediately followed by a load, both with 1-cycle ack → two separate requests with exactly one idle DONE cycle between them; no duplicate request.
- Timeout: TIMEOUT = 8, load never acked → mem_req_o drops after 8 BUSY cycles; err_o = 1 and stays 1 through subsequent accesses; RData_o = 0; pipeline released.
- Reset mid-BUSY: assert rst_i low during the 2nd BUSY cycle → mem_req_o = 0 and Stall_o = 0 asynchronously; after release, a late mem_ack_i is ignored and state remains IDLE.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access sequencer: issues one req/ack transaction per
// load/store, stalls the pipeline until completion, flags timeouts, counts stalls.
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             MemRead_i,
    input  logic             MemWrite_i,
    input  logic [31:0]      Addr_i,
    input  logic [31:0]      WData_i,
    output logic             Stall_o,
    output logic [31:0]      RData_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    input  logic             mem_ack_i,
    input  logic [31:0]      mem_rdata_i,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             access;
    logic             stall;
    logic             tmo_hit;

    assign access  = MemRead_i | MemWrite_i;
    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT - 1));

    // Gated by reset so the pipeline is released the instant reset asserts,
    // even while EX/MEM still presents a memory instruction.
    assign Stall_o = rst_i & stall;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                stall = access;
                if (access) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (mem_ack_i || tmo_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            RData_o     <= '0;
            err_o       <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= MemWrite_i;
                        mem_addr_o  <= Addr_i;
                        mem_wdata_o <= WData_i;
                        tmo_cnt     <= '0;
                    end
                end
                BUSY: begin
                    // Ack wins over a timeout landing in the same cycle.
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        if (!mem_we_o) begin
                            RData_o <= mem_rdata_i;
                        end
                    end else if (tmo_hit) begin
                        mem_req_o <= 1'b0;
                        RData_o   <= '0;
                        err_o     <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
        end else if (Stall_o && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed and random load/store transactions checked
// against a transaction-level model of latency, load data, error flag and stall count.
module tb_dmem_access_ctrl;

    localparam int unsigned TMO = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] Addr_i;
    logic [31:0] WData_i;
    logic        Stall_o;
    logic [31:0] RData_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        err_o;
    logic [15:0] stall_cnt_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_cnt;

    dmem_access_ctrl #(.TIMEOUT(TMO), .CNT_W(16)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .MemRead_i  (MemRead_i),
        .MemWrite_i (MemWrite_i),
        .Addr_i     (Addr_i),
        .WData_i    (WData_i),
        .Stall_o    (Stall_o),
        .RData_o    (RData_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_ack_i  (mem_ack_i),
        .mem_rdata_i(mem_rdata_i),
        .err_o      (err_o),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_rdata"}, RData_o, exp_rdata);
        check({tag, "_err"}, 32'(err_o), 32'(exp_err));
        check({tag, "_cnt"}, 32'(stall_cnt_o), 32'(exp_cnt));
    endtask

    task automatic model_reset();
        exp_rdata = '0;
        exp_err   = 1'b0;
        exp_cnt   = 0;
    endtask

    // One EX/MEM instruction. lat = BUSY cycle in which memory acks; lat > TMO never acks.
    task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdat, input int lat);
        int  n;
        int  exp_n;
        bit  timed_out;
        MemRead_i  = rd;
        MemWrite_i = wr;
        Addr_i     = addr;
        WData_i    = wdata;
        #1;
        check("stall_idle", 32'(Stall_o), 32'(rd | wr));
        if (!(rd | wr)) begin
            mem_ack_i   = 1'($urandom_range(0, 1));
            mem_rdata_i = $urandom;
            @(posedge clk_i); #1;
            mem_ack_i = 1'b0;
            check("req_nomem", 32'(mem_req_o), 32'd0);
            check("rdata_nomem", RData_o, exp_rdata);
            return;
        end
        @(posedge clk_i); #1;
        n = 0;
        while (mem_req_o === 1'b1 && n < int'(TMO) + 4) begin
            n++;
            check("req_we", 32'(mem_we_o), 32'(wr));
            check("req_addr", mem_addr_o, addr);
            check("req_wdata", mem_wdata_o, wdata);
            check("stall_busy", 32'(Stall_o), 32'd1);
            if (n == lat) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = rdat;
            end else begin
                mem_rdata_i = $urandom;
            end
            @(posedge clk_i); #1;
            mem_ack_i = 1'b0;
        end
        timed_out = (lat > int'(TMO));
        exp_n     = timed_out ? int'(TMO) : lat;
        check("busy_len", 32'(n), 32'(exp_n));
        exp_cnt = exp_cnt + exp_n + 1;
        if (exp_cnt > 65535) exp_cnt = 65535;
        if (timed_out) begin
            exp_rdata = '0;
            exp_err   = 1'b1;
        end else if (!wr) begin
            exp_rdata = rdat;
        end
        check("stall_done", 32'(Stall_o), 32'd0);
        check("req_done", 32'(mem_req_o), 32'd0);
        check_state("done");
        mem_ack_i   = 1'($urandom_range(0, 1));
        mem_rdata_i = $urandom;
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        check("req_after_done", 32'(mem_req_o), 32'd0);
        check("rdata_after_done", RData_o, exp_rdata);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i       = 1'b0;
        MemRead_i   = 1'b0;
        MemWrite_i  = 1'b0;
        Addr_i      = '0;
        WData_i     = '0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_req", 32'(mem_req_o), 32'd0);
        check("rst_stall", 32'(Stall_o), 32'd0);
        rst_i = 1'b1;
        repeat (5) begin
            @(posedge clk_i); #1;
            check("idle_stall", 32'(Stall_o), 32'd0);
            check("idle_req", 32'(mem_req_o), 32'd0);
            check("idle_we", 32'(mem_we_o), 32'd0);
            check("idle_addr", mem_addr_o, 32'd0);
            check("idle_wdata", mem_wdata_o, 32'd0);
        end
        check_state("idle");

        txn(1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 3);
        check("load_cnt4", 32'(stall_cnt_o), 32'd4);
        txn(1'b0, 1'b1, 32'h20, 32'h55AA, 32'h12345678, 1);
        check("store_rdata_kept", RData_o, 32'hDEADBEEF);
        txn(1'b0, 1'b1, 32'h24, 32'hA5A5, 32'h0, 1);
        txn(1'b1, 1'b0, 32'h28, 32'h0, 32'hCAFEF00D, 1);
        txn(1'b1, 1'b0, 32'h30, 32'h0, 32'h11112222, int'(TMO));
        check("ack_at_limit_no_err", 32'(err_o), 32'd0);
        txn(1'b1, 1'b0, 32'h40, 32'h0, 32'h33334444, 100);
        check("timeout_err", 32'(err_o), 32'd1);
        txn(1'b1, 1'b1, 32'h44, 32'h9999, 32'h77778888, 2);
        check("err_sticky", 32'(err_o), 32'd1);

        for (int i = 0; i < 150; i++) begin
            int unsigned kind;
            kind = $urandom_range(0, 3);
            txn(kind[0], kind[1], $urandom, $urandom, $urandom,
                int'($urandom_range(1, TMO + 2)));
        end

        MemRead_i  = 1'b1;
        MemWrite_i = 1'b0;
        Addr_i     = 32'h200;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        check("pre_rst_req", 32'(mem_req_o), 32'd1);
        rst_i = 1'b0;
        #1;
        model_reset();
        check("midrst_req", 32'(mem_req_o), 32'd0);
        check("midrst_stall", 32'(Stall_o), 32'd0);
        check_state("midrst");
        MemRead_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hBADBAD00;
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        check("late_ack_req", 32'(mem_req_o), 32'd0);
        check("late_ack_stall", 32'(Stall_o), 32'd0);
        check_state("late_ack");
        txn(1'b1, 1'b0, 32'h300, 32'h0, 32'h0BADF00D, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
